// File: rtl/div_iter_pkg.sv
// Shared CPU definitions: ALU control codes plus the iterative divider's
// width and state encoding.
package div_iter_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLT = 4'h5;
  localparam logic [3:0] ALU_SLL = 4'h6;
  localparam logic [3:0] ALU_SRL = 4'h7;

  typedef logic [1:0] div_state_t;

  localparam div_state_t DIV_IDLE = 2'd0;
  localparam div_state_t DIV_ZERO = 2'd1;
  localparam div_state_t DIV_CALC = 2'd2;
  localparam div_state_t DIV_DONE = 2'd3;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;

  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {2'b00, divisor});
    rem_out = shifted[WIDTH:0] - ({(WIDTH+1){q_bit}} & {1'b0, divisor});
  end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider for the execute stage; result is
// {hi = remainder, lo = quotient} for the HI/LO write.
//
// state | meaning
// IDLE  | waiting for an accepted divide request
// ZERO  | divisor was zero, result forced next cycle
// CALC  | one quotient bit per cycle, WIDTH steps
// DONE  | result registered, ready pulse
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic               annul,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(WIDTH);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .bit_in  (quo_q[WIDTH-1]),
    .divisor (dvsr_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Signed operands enter as magnitudes; signs are reapplied on exit, which
  // makes MIN / -1 wrap back to MIN instead of trapping.
  always_comb begin
    a_abs    = (is_signed && a[WIDTH-1]) ? -a : a;
    b_abs    = (is_signed && b[WIDTH-1]) ? -b : b;
    quo_next = {quo_q[WIDTH-2:0], step_q};
    q_fin    = q_neg ? -quo_next : quo_next;
    r_fin    = r_neg ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
  end

  always_comb begin
    busy  = ~annul & (((state == DIV_IDLE) & start) |
                      (state == DIV_CALC) | (state == DIV_ZERO));
    ready = (state == DIV_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= DIV_IDLE;
      cnt    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      result <= '0;
    end else if (annul) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            if (b != '0) begin
              state  <= DIV_CALC;
              cnt    <= '0;
              rem_q  <= '0;
              quo_q  <= a_abs;
              dvsr_q <= b_abs;
              q_neg  <= (a[WIDTH-1] ^ b[WIDTH-1]) & is_signed;
              r_neg  <= a[WIDTH-1] & is_signed;
            end else begin
              // raw dividend is parked in quo_q to become hi
              state <= DIV_ZERO;
              quo_q <= a;
            end
          end
        end
        DIV_CALC: begin
          rem_q <= step_rem;
          quo_q <= quo_next;
          if (cnt != CNT_SAT) begin
            cnt <= cnt + 1'b1;
          end
          if (cnt == LAST_STEP) begin
            state  <= DIV_DONE;
            result <= {r_fin, q_fin};
          end
        end
        DIV_ZERO: begin
          state  <= DIV_DONE;
          result <= {quo_q, {WIDTH{1'b1}}};
        end
        DIV_DONE: begin
          state <= DIV_IDLE;
        end
        default: begin
          state <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter with hand-computed results.
module tb_div_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        ready;
  logic [63:0] result;

  int checks;
  int failures;

  div_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .annul     (annul),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .ready     (ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide, then follow it to the ready pulse (bounded).
  task automatic run_div(input string tag, input logic [31:0] va,
                         input logic [31:0] vb, input logic sg,
                         input logic [63:0] exp_res, input int exp_lat);
    int lat;
    int busy_bad;
    a = va;
    b = vb;
    is_signed = sg;
    start = 1'b1;
    #1;
    check_val({tag, "_busy_t0"}, {63'd0, busy}, 64'd1);
    tick();
    start = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h0;
    lat = -1;
    busy_bad = 0;
    for (int c = 1; c < 60; c++) begin
      #1;
      if (ready) begin
        lat = c;
        if (busy) busy_bad++;
        break;
      end
      if (!busy) busy_bad++;
      tick();
    end
    check_val({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_val({tag, "_busy_prof"}, 64'(busy_bad), 64'd0);
    check_val({tag, "_result"}, result, exp_res);
    tick();
    check_val({tag, "_ready_off"}, {63'd0, ready}, 64'd0);
  endtask

  initial begin
    int n_ready;
    int first_c;
    int second_c;
    logic [63:0] first_r;
    logic [63:0] second_r;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    annul = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_ready", {63'd0, ready}, 64'd0);
    check_val("rst_result", result, 64'd0);
    rst = 1'b0;
    tick();

    run_div("u_100_7", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33);
    run_div("s_m7_2", 32'hFFFF_FFF9, 32'h2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33);
    run_div("u_big_2", 32'hFFFF_FFF9, 32'h2, 1'b0, {32'h1, 32'h7FFF_FFFC}, 33);
    run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'h1, 32'hFFFF_FFFD}, 33);
    run_div("div0", 32'h1234, 32'h0, 1'b1, {32'h1234, 32'hFFFF_FFFF}, 2);

    // annul in the middle of CALC
    a = 32'd1000;
    b = 32'd3;
    is_signed = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    annul = 1'b1;
    tick();
    annul = 1'b0;
    #1;
    check_val("annul_busy_after", {63'd0, busy}, 64'd0);
    n_ready = 0;
    for (int c = 0; c < 40; c++) begin
      if (ready) n_ready++;
      tick();
    end
    check_val("annul_no_ready", 64'(n_ready), 64'd0);
    check_val("annul_result_kept", result, {32'h1234, 32'hFFFF_FFFF});

    // start held through DONE, then a fresh divide at DONE+1
    n_ready = 0;
    first_c = -1;
    second_c = -1;
    first_r = '0;
    second_r = '0;
    for (int c = 0; c < 80; c++) begin
      start = (c <= 34);
      a = (c < 34) ? 32'd100 : 32'd50;
      b = (c < 34) ? 32'd7 : 32'd5;
      #1;
      if (ready) begin
        n_ready++;
        if (n_ready == 1) begin
          first_c = c;
          first_r = result;
        end else begin
          second_c = c;
          second_r = result;
        end
      end
      tick();
    end
    start = 1'b0;
    check_val("held_ready_cnt", 64'(n_ready), 64'd2);
    check_val("held_first_cyc", 64'(first_c), 64'd33);
    check_val("held_first_res", first_r, {32'h2, 32'hE});
    check_val("held_second_cyc", 64'(second_c), 64'd67);
    check_val("held_second_res", second_r, {32'h0, 32'hA});

    // async reset mid-CALC
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check_val("midrst_busy", {63'd0, busy}, 64'd0);
    check_val("midrst_ready", {63'd0, ready}, 64'd0);
    check_val("midrst_result", result, 64'd0);
    tick();
    rst = 1'b0;
    run_div("u_9_3", 32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 33);

    // start with annul in IDLE is not accepted
    a = 32'd5;
    b = 32'd1;
    start = 1'b1;
    annul = 1'b1;
    #1;
    check_val("idle_annul_busy", {63'd0, busy}, 64'd0);
    tick();
    start = 1'b0;
    annul = 1'b0;
    #1;
    check_val("idle_annul_stay", {63'd0, busy}, 64'd0);
    n_ready = 0;
    for (int c = 0; c < 5; c++) begin
      if (ready) n_ready++;
      tick();
    end
    check_val("idle_annul_noready", 64'(n_ready), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
